// File: rtl/intc_req_if.sv
// Data-memory bus slice seen by the interrupt request controller.
// The CPU side drives select/write/address/data; the controller returns read data.
interface intc_req_if;
    logic        sel;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (output sel, output we, output addr, output wd, input rd);
    modport slave  (input sel, input we, input addr, input wd, output rd);
endinterface

// File: rtl/intc_req.sv
// Fixed-priority interrupt request controller presenting one-hot done1..done4 to the CPU.
// Optional sticky overrun register at 0x10 is built when INTC_OVERRUN_EN is defined.
module intc_req #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            int_ack,
    intc_req_if.slave       bus,
    output logic            done1,
    output logic            done2,
    output logic            done3,
    output logic            done4
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_n;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] overrun;
    logic [1:0]      req_id;
    logic            insvc_valid;
    logic [1:0]      insvc_id;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] ack_clr;
    logic [NSRC-1:0] active;
    logic [2:0]      word;
    logic            wr;
    logic            ack;
    logic            eoi;
    logic [31:0]     rd_val;
    logic            unused_bits;

    function automatic logic [1:0] lowest_set(input logic [NSRC-1:0] v);
        logic [1:0] id;
        id = 2'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (v[i]) id = i[1:0];
        end
        return id;
    endfunction

    assign word        = bus.addr[4:2];
    assign wr          = bus.sel & bus.we;
    assign rise        = irq_src & ~prev;
    assign active      = pending & mask;
    assign ack         = (state == REQ) && int_ack;
    assign eoi         = (state == SERVICE) && wr && (word == 3'd3);
    assign ack_clr     = ack ? (NSRC'(1) << req_id) : '0;
    assign unused_bits = ^{bus.wd[31:NSRC], bus.addr[1:0]};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (|active) state_n = REQ;
            REQ:     if (int_ack) state_n = SERVICE;
            SERVICE: if (eoi)     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A new edge on the source being acknowledged wins over the ack clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev        <= '0;
            pending     <= '0;
            mask        <= '1;
            req_id      <= 2'd0;
            insvc_valid <= 1'b0;
            insvc_id    <= 2'd0;
        end else begin
            prev    <= irq_src;
            pending <= (pending & ~ack_clr) | rise;
            if (wr && word == 3'd1) mask <= bus.wd[NSRC-1:0];
            if (state == IDLE && |active) req_id <= lowest_set(active);
            if (ack) begin
                insvc_valid <= 1'b1;
                insvc_id    <= req_id;
            end else if (eoi) begin
                insvc_valid <= 1'b0;
            end
        end
    end

`ifdef INTC_OVERRUN_EN
    logic [NSRC-1:0] ovr_set;
    logic [NSRC-1:0] ovr_w1c;

    assign ovr_set = rise & pending & ~ack_clr;
    assign ovr_w1c = (wr && word == 3'd4) ? bus.wd[NSRC-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overrun <= '0;
        else       overrun <= (overrun & ~ovr_w1c) | ovr_set;
    end
`else
    assign overrun = '0;
`endif

    always_comb begin
        rd_val = 32'd0;
        if (bus.sel) begin
            case (word)
                3'd0:    rd_val = {{(32-NSRC){1'b0}}, pending};
                3'd1:    rd_val = {{(32-NSRC){1'b0}}, mask};
                3'd2:    rd_val = {29'd0, insvc_valid, insvc_id};
                3'd4:    rd_val = {{(32-NSRC){1'b0}}, overrun};
                default: rd_val = 32'd0;
            endcase
        end
    end

    assign bus.rd = rd_val;

    assign done1 = (state == REQ) && (req_id == 2'd0);
    assign done2 = (state == REQ) && (req_id == 2'd1);
    assign done3 = (state == REQ) && (req_id == 2'd2);
    assign done4 = (state == REQ) && (req_id == 2'd3);

endmodule

// File: doc/intc_req.md
# intc_req

Peripheral-side interrupt request controller for the single-cycle MIPS vectored-interrupt scheme. It latches completion events from up to four accelerators (factorial, multiplier, two spares) and presents exactly one of `done1`..`done4` to the CPU at a time, in fixed priority order. It holds that request until the CPU's `int_ack`, then blocks further requests until the ISR writes end-of-interrupt. It sits on the data-memory bus as a memory-mapped responder beside `dmem`.

## Interface
- `NSRC`, 4: number of sources; fixed at 4 and maps one-to-one onto `done1`..`done4`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `irq_src` in 4: completion level/pulse from accelerators; bit 0 is highest priority.
- `int_ack` in 1: CPU interrupt acknowledge, sampled on `clk`.
- `sel` in 1: bus select, decoded externally from the address.
- `we` in 1: bus write enable; effective only with `sel`.
- `addr` in 5: byte offset; bits [4:2] are used.
- `wd` in 32: write data.
- `rd` out 32: read data; combinational from `addr`; 0 when `sel`=0.
- `done1`, `done2`, `done3`, `done4` out 1 each: one-hot interrupt request to the CPU.

## Operation
- Edge detect: `prev` register per source; a rising edge is `irq_src[i] & ~prev[i]`. A rising edge sets `pending[i]`.
- Register map by word offset:
  - 0x00 PENDING, RO, [3:0].
  - 0x04 MASK, RW, [3:0]; 1 = enabled; reset value 0xF.
  - 0x08 INSERVICE, RO: {bit2 valid, bits1:0 id}.
  - 0x0C EOI, WO: any write ends service.
  - 0x10 OVERRUN: see Configuration.
  - Unmapped offsets read 0; writes to them are ignored.
- FSM with states IDLE, REQ, SERVICE:
  - IDLE: if `pending & mask` is nonzero, load `req_id` = lowest set index and go to REQ.
  - REQ: drive `done{req_id+1}`=1. On `int_ack`=1, clear `pending[req_id]`, set INSERVICE = {1, `req_id`}, go to SERVICE.
  - SERVICE: all `done` lines are 0. On an EOI write, clear INSERVICE valid and go to IDLE.
- Once in REQ, the request is never retracted. Masking or re-prioritising has no effect until the request is acknowledged.
- `int_ack` outside REQ is ignored.
- A rising edge on `pending[req_id]` in the same cycle as its `int_ack` clear leaves pending = 1. The set wins, because it is a new event.
- An EOI write outside SERVICE is ignored.

## Timing
- All outputs are registered state decodes: `done_i` = (state==REQ) && (`req_id`==i-1).
- Reset values: `done1`..`done4`=0, state=IDLE, `pending`=0, `prev`=0, MASK=0xF, INSERVICE=0, OVERRUN=0. `rd` reads 0 when `sel`=0.
- Latency from an edge sampled at posedge k (`irq_src`=1, `prev`=0):
  - `pending` set after posedge k.
  - FSM enters REQ and `done` is high after posedge k+1.
- `int_ack` sampled high at posedge m: `done` low after posedge m.
- EOI write at posedge n: IDLE after n. The next pending request has `done` high after posedge n+1.
- Masked pending bits stay pending. Unmasking one while in IDLE raises `done` one cycle after the MASK write.
- `reset` mid-REQ or mid-SERVICE drops `done` immediately (asynchronously) and discards all pending events.

## Configuration
- `INTC_OVERRUN_EN`
  - Defined: OVERRUN at 0x10 is a sticky [3:0] register. Bit i sets when a rising edge arrives while `pending[i]` is already 1 and is not being cleared that cycle. Writing 1 to a bit clears it (write-1-to-clear). If a set and a write-1 clear hit the same bit in the same cycle, the set wins.
  - Undefined: no overrun logic is built. 0x10 reads 0 and writes to it are ignored.

## Test plan
- Reset, then pulse `irq_src`=0001 for 1 cycle → `done1`=1 two cycles later and held. With `int_ack`=1 for 1 cycle → `done1`=0, INSERVICE=0x4. Write EOI → INSERVICE=0.
- `irq_src`=0110 edge together → `done2` first. After ack+EOI → `done3`. PENDING reads 0100 then 0000.
- MASK=0xE, `irq_src`[0] edge → no `done`, PENDING=0001. Write MASK=0xF → `done1` high one cycle after the write.
- While in REQ for source 2, raise source 0 → `done3` is held (no preemption) until ack. After EOI → `done1`.
- With `INTC_OVERRUN_EN`: two edges on source 1 before ack → OVERRUN=0x2. Write 0x2 → OVERRUN=0. Without the macro → OVERRUN reads 0.
- Assert `reset` while in SERVICE with PENDING=0x8 → all `done` lines=0, PENDING=0, MASK=0xF, and no request after reset is released.
